// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the five-stage SCPU pipeline. It combines
// three sources of pipeline control, in priority order:
//   1. a data-memory wait (mem_req without mem_ack),
//   2. a taken branch/jump resolved in EX,
//   3. a load-use hazard between EX and ID.
// A three-state FSM (RUN / MEM_WAIT / FAULT) tracks long memory waits and
// raises a sticky fault when the wait exceeds TIMEOUT cycles. Two wrapping
// counters report stall cycles and branch flushes to the debug path.
//
// All stall/flush outputs are combinational from the current inputs and the
// registered state, so the pipeline registers act on them at the same edge.
// The top-level port names are fixed by the surrounding SCPU netlist.

`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,   // legal range 2..65535
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             mem_fault,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // The first hold cycle is spent in RUN with the counter at 0, so the
    // counter's incremented value reaching TIMEOUT-1 inside MEM_WAIT marks
    // the TIMEOUT-th consecutive hold cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      wait_cnt_q;
    logic [15:0]      wait_cnt_d;
    logic [15:0]      wait_inc_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic mem_hold_s;
    logic rs1_hit_s;
    logic rs2_hit_s;
    logic load_use_s;

    logic pc_stall_s;
    logic ifid_stall_s;
    logic ifid_flush_s;
    logic idex_stall_s;
    logic idex_flush_s;
    logic exmem_stall_s;
    logic memwb_flush_s;

    // Hazard detection terms; x0 never creates a dependency.
    always_comb begin
        mem_hold_s = mem_req & ~mem_ack;
        rs1_hit_s  = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        rs2_hit_s  = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        load_use_s = ex_mem_read & (ex_rd_addr != 5'd0) & (rs1_hit_s | rs2_hit_s);
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic: enter MEM_WAIT on a hold, leave on ack, fault on timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 16'd0;
        wait_inc_s = wait_cnt_q + 16'd1;
        case (state_q)
            ST_RUN: begin
                if (mem_hold_s) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                wait_cnt_d = wait_inc_s;
                if (mem_ack) begin
                    // An ack on the timeout cycle wins over the fault.
                    state_d = ST_RUN;
                end else if (wait_inc_s == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_FAULT: begin
                state_d    = ST_FAULT;
                wait_cnt_d = wait_cnt_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Stall/flush outputs by priority: reset, fault, memory hold, branch, load-use.
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_stall_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_stall_s = 1'b0;
        memwb_flush_s = 1'b0;
        if (rst) begin
            pc_stall_s = 1'b0;
        end else if (state_q == ST_FAULT) begin
            // Freeze the whole pipeline and keep bubbling MEM/WB.
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_stall_s  = 1'b1;
            exmem_stall_s = 1'b1;
            memwb_flush_s = 1'b1;
        end else if (mem_hold_s) begin
            // EX is held too, so a concurrent branch re-presents later.
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_stall_s  = 1'b1;
            exmem_stall_s = 1'b1;
            memwb_flush_s = 1'b1;
        end else if (ex_branch_taken) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed.
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else if (load_use_s) begin
            // Hold the consumer in ID for one cycle and bubble EX.
            pc_stall_s   = 1'b1;
            ifid_stall_s = 1'b1;
            idex_flush_s = 1'b1;
        end else begin
            pc_stall_s = 1'b0;
        end
    end

    // Next values of the statistics counters; both wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall_s);
        flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush_s);
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_stall     = pc_stall_s;
    assign ifid_stall   = ifid_stall_s;
    assign ifid_flush   = ifid_flush_s;
    assign idex_stall   = idex_stall_s;
    assign idex_flush   = idex_flush_s;
    assign exmem_stall  = exmem_stall_s;
    assign memwb_flush  = memwb_flush_s;
    assign mem_fault    = (state_q == ST_FAULT);
    assign state        = state_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule
